// File: rtl/sa3x3_feeder.sv
// Host-side sequencer for a 3x3 systolic MAC array: clears the array, streams one
// kernel/patch column per cycle on the row lanes, waits out the diagonal drain and
// returns the array sum on a valid/ready port.
module sa3x3_feeder #(
    parameter int DW    = 8,
    parameter int DRAIN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ker_load,
    input  logic [9*DW-1:0] ker_data,
    input  logic          start,
    input  logic [9*DW-1:0] patch,
    output logic          ready,
    output logic [DW-1:0] din0,
    output logic [DW-1:0] din1,
    output logic [DW-1:0] din2,
    output logic [DW-1:0] win0,
    output logic [DW-1:0] win1,
    output logic [DW-1:0] win2,
    output logic          clear,
    input  logic [DW-1:0] arr_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_DRN,
        S_HOLD
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [9*DW-1:0] ker_q, patch_q;
    logic [2:0][DW-1:0] din_q, win_q, din_nxt, win_nxt;
    logic clear_q, ready_q, res_valid_q;
    logic [DW-1:0] res_data_q;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLR;
                    cnt_nxt   = '0;
                end
            end
            S_CLR: begin
                state_nxt = S_FEED;
                cnt_nxt   = '0;
            end
            S_FEED: begin
                if (cnt == 4'd2) begin
                    state_nxt = S_DRN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DRN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_HOLD: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lanes are registered from the next state, so FEED column k is on the wires
    // exactly while the state register says FEED k.
    always_comb begin
        din_nxt = '0;
        win_nxt = '0;
        if (state_nxt == S_FEED) begin
            for (int r = 0; r < 3; r++) begin
                din_nxt[r] = patch_q[DW*(3*r + int'(cnt_nxt[1:0])) +: DW];
                win_nxt[r] = ker_q[DW*(3*r + int'(cnt_nxt[1:0])) +: DW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order. The kernel and patch
    // stores are small enough to be plain reset flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ker_q       <= '0;
            patch_q     <= '0;
            din_q       <= '0;
            win_q       <= '0;
            clear_q     <= 1'b0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            din_q   <= din_nxt;
            win_q   <= win_nxt;
            clear_q <= (state_nxt == S_CLR);
            ready_q <= (state_nxt == S_IDLE);
            if (state == S_IDLE && ker_load) ker_q   <= ker_data;
            if (state == S_IDLE && start)    patch_q <= patch;
            if (state == S_DRN && cnt == DRAIN_LAST) begin
                res_data_q  <= arr_out;
                res_valid_q <= 1'b1;
            end else if (state == S_HOLD && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign ready     = ready_q;
    assign clear     = clear_q;
    assign din0      = din_q[0];
    assign din1      = din_q[1];
    assign din2      = din_q[2];
    assign win0      = win_q[0];
    assign win1      = win_q[1];
    assign win2      = win_q[2];
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_sa3x3_feeder.sv
// Directed bench for sa3x3_feeder with a behavioural stand-in for the 3x3 array:
// accumulate register plus two skew stages, cleared by the feeder's clear pulse.
module tb_sa3x3_feeder;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ker_load = 1'b0;
    logic [9*DW-1:0] ker_data = '0;
    logic          start = 1'b0;
    logic [9*DW-1:0] patch = '0;
    logic          ready;
    logic [DW-1:0] din0, din1, din2, win0, win1, win2;
    logic          clear;
    logic [DW-1:0] arr_out;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    sa3x3_feeder #(.DW(DW), .DRAIN(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .ker_load (ker_load),
        .ker_data (ker_data),
        .start    (start),
        .patch    (patch),
        .ready    (ready),
        .din0     (din0),
        .din1     (din1),
        .din2     (din2),
        .win0     (win0),
        .win1     (win1),
        .win2     (win2),
        .clear    (clear),
        .arr_out  (arr_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data)
    );

    always #5 clk = ~clk;

    // Array stand-in: dot product accumulates mod 2^8, result appears two cycles later.
    logic [DW-1:0] acc = '0, skew1 = '0, skew2 = '0;
    always @(posedge clk) begin
        if (clear) acc <= '0;
        else       acc <= acc + DW'(din0 * win0) + DW'(din1 * win1) + DW'(din2 * win2);
        skew1 <= acc;
        skew2 <= skew1;
    end
    assign arr_out = skew2;

    function automatic logic [9*DW-1:0] fill(input logic [DW-1:0] v);
        return {9{v}};
    endfunction

    task automatic load_kernel(input logic [9*DW-1:0] k);
        ker_load = 1'b1;
        ker_data = k;
        @(negedge clk);
        ker_load = 1'b0;
        ker_data = '0;
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic accept(input logic [9*DW-1:0] p);
        start = 1'b1;
        patch = p;
        @(negedge clk);
        start = 1'b0;
        patch = '0;
    endtask

    task automatic wait_result(input int from, output int lat);
        lat = from;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_job(input logic [9*DW-1:0] p, output int lat, output logic [DW-1:0] data);
        accept(p);
        wait_result(0, lat);
        data = res_data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({din0, din1, din2, win0, win1, win2, clear, res_valid, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lanes=%h clear=%b valid=%b data=%0d, need all 0",
                     {din0, din1, din2, win0, win1, win2}, clear, res_valid, res_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b need 1", ready);
        end
    endtask

    task automatic test_ones;
        int n, clear_cnt, clr_at, feed_cnt;
        res_ready = 1'b1;
        load_kernel(fill(8'd1));
        accept(fill(8'd1));
        n = 0; clear_cnt = 0; clr_at = -1; feed_cnt = 0;
        while (n < 40) begin
            if (clear) begin
                clear_cnt++;
                if (clr_at < 0) clr_at = n;
            end
            if (din0 !== '0) feed_cnt++;
            if (res_valid) break;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (clear_cnt != 1 || clr_at != 0) begin
            n_fail++;
            $display("FAIL ones_clear: got %0d cycles at offset %0d, need 1 cycle at 0", clear_cnt, clr_at);
        end
        n_checks++;
        if (feed_cnt != 3) begin
            n_fail++;
            $display("FAIL ones_feed_len: got %0d need 3", feed_cnt);
        end
        n_checks++;
        if (n != 7) begin
            n_fail++;
            $display("FAIL ones_latency: got %0d need 7", n);
        end
        n_checks++;
        if (res_data !== 8'd9) begin
            n_fail++;
            $display("FAIL ones_data: got %0d need 9", res_data);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_transfer: got valid=%b ready=%b need 0/1", res_valid, ready);
        end
    endtask

    task automatic test_packing;
        logic [9*DW-1:0] p, k;
        logic [DW-1:0] exp_d[3], exp_w[3];
        int lat;
        p = '0;
        for (int i = 0; i < 9; i++) p[DW*i +: DW] = DW'(i + 1);
        k = '0;
        k[DW*4 +: DW] = 8'd1;
        load_kernel(k);
        accept(p);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                exp_d[r] = DW'(3*r + c + 1);
                exp_w[r] = (r == 1 && c == 1) ? 8'd1 : 8'd0;
            end
            n_checks++;
            if ({din0, din1, din2} !== {exp_d[0], exp_d[1], exp_d[2]}) begin
                n_fail++;
                $display("FAIL pack_din_k%0d: got %0d,%0d,%0d need %0d,%0d,%0d",
                         c, din0, din1, din2, exp_d[0], exp_d[1], exp_d[2]);
            end
            n_checks++;
            if ({win0, win1, win2} !== {exp_w[0], exp_w[1], exp_w[2]}) begin
                n_fail++;
                $display("FAIL pack_win_k%0d: got %0d,%0d,%0d need %0d,%0d,%0d",
                         c, win0, win1, win2, exp_w[0], exp_w[1], exp_w[2]);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({din0, din1, din2, win0, win1, win2, clear} !== '0) begin
            n_fail++;
            $display("FAIL pack_drain_lanes: got %h need 0", {din0, din1, din2, win0, win1, win2});
        end
        wait_result(4, lat);
        n_checks++;
        if (lat != 7 || res_data !== 8'd5) begin
            n_fail++;
            $display("FAIL pack_result: got %0d after %0d cycles, need 5 after 7", res_data, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int lat;
        logic [DW-1:0] data;
        load_kernel(fill(8'd15));
        run_job(fill(8'd15), lat, data);
        n_checks++;
        if (lat != 7 || data !== 8'd233) begin
            n_fail++;
            $display("FAIL wrap_result: got %0d after %0d cycles, need 233 after 7", data, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_hold;
        int lat;
        logic [DW-1:0] data;
        load_kernel(fill(8'd1));
        res_ready = 1'b0;
        run_job(fill(8'd3), lat, data);
        n_checks++;
        if (lat != 7 || data !== 8'd27) begin
            n_fail++;
            $display("FAIL hold_result: got %0d after %0d cycles, need 27 after 7", data, lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 8'd27 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable_%0d: got valid=%b data=%0d ready=%b need 1/27/0",
                         i, res_valid, res_data, ready);
            end
            if (i == 1) begin
                start = 1'b1; patch = fill(8'd5);
                ker_load = 1'b1; ker_data = fill(8'd7);
            end
            @(negedge clk);
            start = 1'b0; patch = '0;
            ker_load = 1'b0; ker_data = '0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_transfer: got valid=%b ready=%b need 0/1", res_valid, ready);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || clear !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_queue: got ready=%b clear=%b need 1/0", ready, clear);
        end
        run_job(fill(8'd2), lat, data);
        n_checks++;
        if (lat != 7 || data !== 8'd18) begin
            n_fail++;
            $display("FAIL hold_old_kernel: got %0d after %0d cycles, need 18 after 7", data, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midjob;
        int lat, seen;
        logic [DW-1:0] data;
        load_kernel(fill(8'd1));
        accept(fill(8'd1));
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (din0 !== 8'd1 || win0 !== 8'd1) begin
            n_fail++;
            $display("FAIL midjob_feeding: got din0=%0d win0=%0d need 1/1", din0, win0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({din0, din1, din2, win0, win1, win2, clear, res_valid, res_data} !== '0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midjob_reset: got lanes=%h clear=%b valid=%b data=%0d ready=%b need 0s, ready 1",
                     {din0, din1, din2, win0, win1, win2}, clear, res_valid, res_data, ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midjob_no_result: got res_valid for %0d cycles need 0", seen);
        end
        load_kernel(fill(8'd2));
        run_job(fill(8'd3), lat, data);
        n_checks++;
        if (lat != 7 || data !== 8'd54) begin
            n_fail++;
            $display("FAIL midjob_next: got %0d after %0d cycles, need 54 after 7", data, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_same_cycle_load;
        int lat;
        load_kernel(fill(8'd0));
        ker_load = 1'b1; ker_data = fill(8'd1);
        start = 1'b1;    patch = fill(8'd2);
        @(negedge clk);
        ker_load = 1'b0; ker_data = '0;
        start = 1'b0;    patch = '0;
        wait_result(0, lat);
        n_checks++;
        if (lat != 7 || res_data !== 8'd18) begin
            n_fail++;
            $display("FAIL same_cycle: got %0d after %0d cycles, need 18 after 7", res_data, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ones();
        test_packing();
        test_wrap();
        test_back_to_back_hold();
        test_reset_midjob();
        test_same_cycle_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa3x3_feeder.md
Name: sa3x3_feeder

Overview:
- Sequencer that drives a 3x3 systolic MAC array (PE grid, diagonal-sum output) from the host side.
- Holds a 3x3 kernel and accepts a 3x3 pixel patch per job. Pulses the array's clear, streams each row on its din/win lane over 3 cycles, and waits for the diagonal pipeline to drain.
- Captures the array's 8-bit output and presents it on a valid/ready result port.
- Sits between the patch/line-buffer logic and the array instance.

Parameters:
- DW, 8, element width of pixels, weights and result. Must match the array.
- DRAIN, 3, cycles after the last feed cycle before the array output is sampled. Legal range 3..15. Minimum 3 covers the two-register diagonal skew plus the PE accumulate register.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ker_load  in  1  kernel write strobe, honoured in IDLE only.
- ker_data  in  9*DW  kernel. Element (r,c) is at bits [DW*(3r+c) +: DW].
- start  in  1  job request.
- patch  in  9*DW  pixel patch, same packing as ker_data. Sampled when start is accepted.
- ready  out  1  high in IDLE. A start is accepted when start && ready.
- din0, din1, din2  out  DW each  pixel lanes to array rows 0..2.
- win0, win1, win2  out  DW each  weight lanes to array columns 0..2.
- clear  out  1  array accumulator clear.
- arr_out  in  DW  array result (sum of the diagonal accumulators).
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  DW  captured result.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE; kernel and patch registers go to 0.
  - Registered outputs go to 0: din*, win*, clear, res_valid, res_data. ready=1 in the cycle after reset.
  - Reset mid-job aborts with no result. The next job's CLR cycle re-zeroes the accumulators.
- States: IDLE -> CLR -> FEED (k = 0,1,2) -> DRN (count 0..DRAIN-1) -> HOLD -> IDLE.
- IDLE:
  - ready=1.
  - ker_load=1 latches ker_data.
  - start=1 latches patch and goes to CLR.
  - If ker_load and start arrive in the same cycle, the new kernel is used for that job.
  - ker_load outside IDLE is ignored; the kernel is unchanged.
  - start outside IDLE is ignored; no queueing.
- CLR: one cycle. clear=1 and all lanes = 0.
- FEED k:
  - Drives din_r = patch(r,k) and win_r = ker(r,k) for r = 0..2. All three rows are driven in the same cycle; the array provides the diagonal skew.
  - clear=0.
- DRN: all lanes 0, clear=0. Zeros add nothing to the accumulators and flush the array's din/wout pipeline registers.
- Sampling:
  - On the clk edge ending DRN count DRAIN-1, res_data <= arr_out and res_valid <= 1.
  - State goes to HOLD.
- Latency: result visible (res_valid=1) exactly 4+DRAIN cycles after the accepting edge. Default is 7.
- HOLD:
  - res_valid=1; res_data is stable until the transfer.
  - Transfer on res_valid && res_ready; then res_valid <= 0 and state goes to IDLE, so ready=1 the next cycle.
  - If res_ready is already high when HOLD is entered, the transfer happens on the first HOLD cycle.
  - Back-to-back throughput is one job per 6+DRAIN cycles.
- Lanes and clear: all outputs are driven from registers; lanes are 0 in every state except FEED.
- Arithmetic: the result is modulo 2^DW, matching the array's 8-bit PE products and adders. The feeder performs no arithmetic on data.

Test Plan:
- Reset, then ker_load all-ones, start with patch all-ones, res_ready=1 -> clear high for exactly 1 cycle; FEED for 3 cycles; res_valid rises 7 cycles after accept; res_data=9.
- Kernel center=1 (others 0), patch values 1..9 in row-major order -> res_data=5. Check din/win lane values in each FEED cycle against the packing rule.
- Kernel all 15, patch all 15 -> 9*225 = 2025 mod 256, so res_data=233 (wrap check).
- Hold res_ready=0 for 5 cycles after res_valid:
  - res_data is stable and ready=0.
  - A start and a ker_load pulsed during HOLD are ignored.
  - After res_ready=1, the next job still uses the old kernel.
- Assert rst during FEED k=1:
  - All outputs are 0 and ready=1 after the reset edge; no res_valid.
  - A new job with kernel all 2 and patch all 3 -> res_data=54.
- ker_load (kernel all 1) and start (patch all 2) in the same IDLE cycle, with the previous kernel all 0 -> res_data=18.
